// File: rtl/div_pow2_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_pow2_pkg : shared constants, shift clamp and buffer entry type | rev 1.0
// ---------------------------------------------------------------------------
package div_pow2_pkg;

    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_SHIFT_W = 3;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] q;
        logic [DEFAULT_DATA_W-1:0] rem;
    } entry_t;

    function automatic int unsigned clamp_shift(input int unsigned k,
                                                input int unsigned data_w);
        return (k > data_w - 1) ? data_w - 1 : k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_pow2_stream_out_fifo2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// out_fifo2 : 2-entry synchronous FIFO, head reads as zero when empty | rev 1.0
// ---------------------------------------------------------------------------
module out_fifo2
    import div_pow2_pkg::*;
#(
    parameter type T = entry_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     head,
    output logic full,
    output logic empty
);

    T           mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= T'('0);
            mem[1] <= T'('0);
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // simultaneous push and pop leaves the occupancy unchanged
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign head  = empty ? T'('0) : mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/div_pow2_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_pow2_stream : streaming divide by 2^k with rounding/sign per beat | rev 1.0
// ---------------------------------------------------------------------------
module div_pow2_stream
    import div_pow2_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int SHIFT_W = DEFAULT_SHIFT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               data_valid,
    output logic               data_ready,
    input  logic [SHIFT_W-1:0] shift_amt,
    input  logic               round_en,
    input  logic               signed_en,
    output logic [DATA_W-1:0]  data_out,
    output logic [DATA_W-1:0]  data_rem,
    output logic               data_valid_out,
    input  logic               data_ready_in
);

    typedef struct packed {
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] rem;
    } beat_t;

    localparam logic [DATA_W:0]   ONE      = (DATA_W+1)'(1);
    localparam logic [DATA_W-1:0] ALL_ONES = '1;

    int unsigned        k;
    logic [DATA_W:0]    operand;
    logic [DATA_W:0]    bias;
    logic [DATA_W:0]    biased;
    logic [DATA_W-1:0]  mask;
    beat_t              new_entry;
    beat_t              head;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;

    // One guard bit keeps the rounding bias from overflowing either signedness.
    always_comb begin
        k       = clamp_shift(32'(shift_amt), DATA_W);
        operand = signed_en ? {data_in[DATA_W-1], data_in} : {1'b0, data_in};
        bias    = '0;
        if (round_en && (k != 0)) begin
            bias = ONE << (k - 1);
        end
        biased  = operand + bias;
        mask    = ~(ALL_ONES << k);
        new_entry.rem = data_in & mask;
        if (signed_en) begin
            new_entry.q = DATA_W'($signed(biased) >>> k);
        end else begin
            new_entry.q = DATA_W'(biased >> k);
        end
    end

    assign data_ready     = !full && !reset;
    assign push           = data_valid && data_ready;
    assign data_valid_out = !empty;
    assign pop            = data_valid_out && data_ready_in;

    out_fifo2 #(
        .T (beat_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (new_entry),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign data_out = head.q;
    assign data_rem = head.rem;

endmodule
`default_nettype wire

// File: tb/tb_div_pow2_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_div_pow2_stream : directed bench for div_pow2_stream | rev 1.0
// ---------------------------------------------------------------------------
module tb_div_pow2_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [2:0] shift_amt;
    logic       round_en;
    logic       signed_en;
    logic [7:0] data_out;
    logic [7:0] data_rem;
    logic       data_valid_out;
    logic       data_ready_in;

    logic [11:0] d12;
    logic        v12;
    logic        rdy12;
    logic [3:0]  k12;
    logic        rnd12;
    logic [11:0] o12;
    logic [11:0] r12;
    logic        vo12;

    int errors = 0;
    int checks = 0;
    logic [15:0] popq[$];

    always #5 clk = ~clk;

    div_pow2_stream #(.DATA_W(8), .SHIFT_W(3)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .shift_amt      (shift_amt),
        .round_en       (round_en),
        .signed_en      (signed_en),
        .data_out       (data_out),
        .data_rem       (data_rem),
        .data_valid_out (data_valid_out),
        .data_ready_in  (data_ready_in)
    );

    div_pow2_stream #(.DATA_W(12), .SHIFT_W(4)) u_dut12 (
        .clk            (clk),
        .reset          (reset),
        .data_in        (d12),
        .data_valid     (v12),
        .data_ready     (rdy12),
        .shift_amt      (k12),
        .round_en       (rnd12),
        .signed_en      (1'b0),
        .data_out       (o12),
        .data_rem       (r12),
        .data_valid_out (vo12),
        .data_ready_in  (1'b1)
    );

    // Record every beat that leaves the 8-bit instance.
    always @(negedge clk) begin
        if (data_valid_out && data_ready_in) popq.push_back({data_out, data_rem});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer a beat until it is taken (bounded), then drop data_valid.
    task automatic send(input logic [7:0] d, input logic [2:0] k, input logic r, input logic s);
        data_in    = d;
        shift_amt  = k;
        round_en   = r;
        signed_en  = s;
        data_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (data_ready) break;
        end
        check("send_ready", {31'd0, data_ready}, 32'd1);
        @(posedge clk);
        #1 data_valid = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic [2:0] k, input logic r,
                        input logic s, input logic [7:0] eq, input logic [7:0] er);
        send(d, k, r, s);
        @(negedge clk);
        check("beat_valid", {31'd0, data_valid_out}, 32'd1);
        check("beat_q", {24'd0, data_out}, {24'd0, eq});
        check("beat_rem", {24'd0, data_rem}, {24'd0, er});
        @(posedge clk);
        #1;
    endtask

    logic [7:0] vd [6] = '{8'h81, 8'hFF, 8'h41, 8'h81, 8'h80, 8'hC0};
    logic [2:0] vk [6] = '{3'd2, 3'd1, 3'd0, 3'd2, 3'd1, 3'd7};
    logic       vr [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] vq [6] = '{8'h20, 8'h80, 8'h41, 8'hE0, 8'hC0, 8'h01};
    logic [7:0] vm [6] = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h40};

    initial begin
        reset = 1'b1; data_in = '0; data_valid = 1'b0; shift_amt = '0;
        round_en = 1'b0; signed_en = 1'b0; data_ready_in = 1'b1;
        d12 = '0; v12 = 1'b0; k12 = '0; rnd12 = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, data_valid_out}, 32'd0);
        check("rst_out", {24'd0, data_out}, 32'd0);
        check("rst_rem", {24'd0, data_rem}, 32'd0);
        check("rst_ready", {31'd0, data_ready}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rel_ready", {31'd0, data_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back unsigned truncate, k=2
        data_in = 8'h75; shift_amt = 3'd2; data_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b2b_v1", {31'd0, data_valid_out}, 32'd1);
        check("b2b_q1", {24'd0, data_out}, 32'h1D);
        check("b2b_r1", {24'd0, data_rem}, 32'h01);
        @(posedge clk);
        #1 data_valid = 1'b0;
        @(negedge clk);
        check("b2b_v2", {31'd0, data_valid_out}, 32'd1);
        check("b2b_q2", {24'd0, data_out}, 32'h1D);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b2b_idle_v", {31'd0, data_valid_out}, 32'd0);
        check("b2b_idle_q", {24'd0, data_out}, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) beat(vd[i], vk[i], vr[i], vs[i], vq[i], vm[i]);

        // Backpressure
        popq.delete();
        data_ready_in = 1'b0;
        send(8'h41, 3'd2, 1'b0, 1'b0);
        send(8'h35, 3'd2, 1'b0, 1'b0);
        data_in = 8'h75; data_valid = 1'b1;
        @(negedge clk);
        check("bp_full_ready", {31'd0, data_ready}, 32'd0);
        check("bp_head_v", {31'd0, data_valid_out}, 32'd1);
        check("bp_head_q", {24'd0, data_out}, 32'h10);
        @(negedge clk);
        check("bp_hold_q", {24'd0, data_out}, 32'h10);
        check("bp_hold_rem", {24'd0, data_rem}, 32'h01);
        @(posedge clk);
        #1 data_ready_in = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (data_ready) break;
        end
        check("bp_reopen", {31'd0, data_ready}, 32'd1);
        @(posedge clk);
        #1 data_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_count", popq.size(), 32'd3);
        if (popq.size() == 3) begin
            check("bp_0", {16'd0, popq[0]}, 32'h1001);
            check("bp_1", {16'd0, popq[1]}, 32'h0D01);
            check("bp_2", {16'd0, popq[2]}, 32'h1D01);
        end

        // Wide build: shift_amt=15 clamps to k=11
        d12 = 12'hC00; k12 = 4'd15; rnd12 = 1'b0; v12 = 1'b1;
        @(negedge clk);
        check("w12_ready", {31'd0, rdy12}, 32'd1);
        @(posedge clk);
        #1 rnd12 = 1'b1;
        @(negedge clk);
        check("w12_q_trunc", {20'd0, o12}, 32'h001);
        check("w12_rem", {20'd0, r12}, 32'h400);
        @(posedge clk);
        #1 v12 = 1'b0;
        @(negedge clk);
        check("w12_valid", {31'd0, vo12}, 32'd1);
        check("w12_q_round", {20'd0, o12}, 32'h002);
        @(posedge clk);
        #1;

        // Reset with two beats buffered
        data_ready_in = 1'b0;
        send(8'h41, 3'd2, 1'b0, 1'b0);
        send(8'h35, 3'd2, 1'b0, 1'b0);
        reset = 1'b1; data_in = 8'h99; data_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", {31'd0, data_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_valid", {31'd0, data_valid_out}, 32'd0);
        check("mid_rst_out", {24'd0, data_out}, 32'd0);
        check("mid_rst_ready2", {31'd0, data_ready}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0; data_valid = 1'b0; data_ready_in = 1'b1;
        popq.delete();
        @(negedge clk);
        check("post_rst_ready", {31'd0, data_ready}, 32'd1);
        check("post_rst_valid", {31'd0, data_valid_out}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_drained", popq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/div_pow2_stream.md
# div_pow2_stream

Streaming power-of-two divider: each accepted beat is divided by 2^k, with k, rounding and signedness chosen per beat at run time. The quotient and the discarded low bits are returned through a valid/ready interface. It sits in the sample datapath as the parametrised successor of the fixed divide-by-4 block. It adds width and shift parametrisation, rounding, signed operands and downstream backpressure through a 2-entry output buffer.

## Interface
Parameters:
- DATA_W, 8, operand/quotient width
- SHIFT_W, 3, width of shift_amt

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- data_in  in  DATA_W  operand
- data_valid  in  1  upstream beat valid
- data_ready  out  1  block can accept a beat this cycle
- shift_amt  in  SHIFT_W  k; sampled with the beat; values > DATA_W-1 clamp to DATA_W-1
- round_en  in  1  0 = floor (truncate), 1 = round half up; sampled with the beat
- signed_en  in  1  1 = data_in is two's complement; sampled with the beat
- data_out  out  DATA_W  quotient at FIFO head
- data_rem  out  DATA_W  low k bits of the operand, zero-extended
- data_valid_out  out  1  head entry valid
- data_ready_in  in  1  downstream accepts head

## Operation
- Accept when data_valid && data_ready.
- Compute combinationally at accept and write {q, rem} into the 2-entry buffer. Config is never re-sampled after accept.
- Internal width DATA_W+1:
  - Operand is sign-extended if signed_en, otherwise zero-extended.
  - If round_en and k>0, add 2^(k-1).
  - Shift right by k: arithmetic if signed_en, logical otherwise.
  - The low DATA_W bits are q. Overflow cannot occur.
- rem = data_in & (2^k-1), independent of round_en.
- k=0: q=data_in, rem=0.
- Pop when data_valid_out && data_ready_in.
- data_ready = (count != 2) && !reset. It has no combinational path from data_ready_in.
- Buffer boundary conditions:
  - Push and pop together with count=1: count stays 1, and the new beat is the head next cycle.
  - Push and pop together with count=2: not possible, because data_ready=0.
  - count=0 with a push: data_valid_out rises the next cycle.
- data_out/data_rem hold their value while data_valid_out=1 and data_ready_in=0.
- When data_valid_out=0, data_out/data_rem are 0.

## Timing
- Latency: accept at edge N gives data_valid_out=1 after edge N; data is visible in cycle N+1.
- Throughput: 1 beat/cycle while data_ready_in=1.
- Reset, and every output reset value:
  - count=0, both entries cleared.
  - data_out=0, data_rem=0, data_valid_out=0.
  - data_ready=0 while reset is high; it is 1 in the first cycle after reset drops.
- Reset mid-stream: all buffered beats are discarded, and no beat is accepted in a reset cycle.
- data_valid is allowed to drop at any time. Upstream does not have to hold data while data_ready=0; beats are simply not taken.

## Structure
- Package div_pow2_pkg:
  - Constants for default DATA_W and SHIFT_W.
  - Function clamp_shift(k).
  - Packed struct entry_t {q, rem}.
- Sub-module out_fifo2: a 2-entry synchronous FIFO of entry_t with push, pop, full, empty and head. Its reset behaviour is as above.
- Top level: the arithmetic datapath plus ready/valid glue.

## Test plan
- Unsigned, truncate, k=2, data_in=0x75 then 0x75 back-to-back, data_ready_in=1 -> two beats 0x1D/rem 0x01 on consecutive cycles, 1 cycle after each accept.
- Unsigned, round, k=2: 0x81 -> 0x20/rem 0x01. k=1, 0xFF -> 0x80/rem 0x01. k=0, 0x41 -> 0x41/rem 0x00.
- Signed, truncate, k=2: 0x81 (-127) -> 0xE0 (-32)/rem 0x01. Signed, round, k=1: 0x80 (-128) -> 0xC0/rem 0x00.
- Backpressure, data_ready_in=0, offer 0x41, 0x35, 0x75 (k=2, truncate):
  - 0x41 and 0x35 are accepted.
  - data_ready=0 while 0x75 is held.
  - Raise data_ready_in -> outputs 0x10, 0x0D, 0x1D in order, no loss or duplication.
- Clamp: shift_amt=7 with DATA_W=8 behaves as k=7, so unsigned truncate of 0xC0 -> 0x01/rem 0x40. Run a DATA_W=12, SHIFT_W=4 build with shift_amt=15 -> clamps to k=11.
- Reset: assert reset with 2 beats buffered -> next cycle data_valid_out=0, data_out=0, data_ready=0. First cycle after release data_ready=1, and the discarded beats never appear.
